decodificador_seq_param: RTL
============================

# decodificador_seq_param

Parametrised sequence decoder: consumes one CHAR_W-bit character per strobe, tracks progress through a SEQ_LEN-character code sequence with single-step corrections, and terminates in accept-A, accept-B or invalid. Generalises the fixed 7-bit, 5-step decoder FSM with a runtime-programmable code table, configurable depth and split point, an inactivity timeout and a synchronous clear. It sits behind the character front-end and drives the status/result logic.

## Interface
- CHAR_W, 7: character width.
- SEQ_LEN, 5: sequence characters C1..C_SEQ_LEN (≥2).
- SPLIT, 3: depths 1..SPLIT accept code A; depths SPLIT+1..SEQ_LEN accept code B (1 ≤ SPLIT < SEQ_LEN).
- TIMEOUT, 0: idle cycles in an active state before forced INVALID; 0 disables.
- DEFAULT_TABLE, {7'b1010011,7'b1110101,7'b1001001,7'b1101110,7'b1011010,7'b1111100,7'b1000100,7'b1100000}: reset contents, entry 0 in LSBs.
- Derived: DW = $clog2(SEQ_LEN+1), AW = $clog2(SEQ_LEN+3).
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Limpar  in  1  synchronous clear to IDLE.
- Controle  in  1  character strobe; Entrada consumed on each edge where high.
- Entrada  in  CHAR_W  character.
- prog_we  in  1  table write enable.
- prog_addr  in  AW  entry: 0..SEQ_LEN-1 = C1..C_N, SEQ_LEN = accept-A, SEQ_LEN+1 = abort, SEQ_LEN+2 = accept-B.
- prog_data  in  CHAR_W  entry value.
- estado  out  DW  current depth (0 in IDLE and terminal states).
- Saida  out  2  00 idle/running, 01 DONE_A, 10 DONE_B, 11 INVALID.
- fim  out  1  one-cycle pulse on entry to any terminal state.

## Operation
- States: IDLE, ACTIVE(k) k=1..SEQ_LEN, DONE_A, DONE_B, INVALID. Table indices 0-based: T[i] = C_(i+1).
- IDLE + strobe: Entrada==T[0] → ACTIVE(1); any other character ignored (stay IDLE, no fim).
- ACTIVE(k) + strobe, first match wins:
  - k<SEQ_LEN and Entrada==T[k] → ACTIVE(k+1) (advance).
  - Entrada==T[k-1] → stay ACTIVE(k) (repeat).
  - k≥2 and Entrada==T[k-2] → ACTIVE(k-1) (correction, one step only).
  - Entrada==accept-A and k≤SPLIT → DONE_A.
  - Entrada==accept-B and k>SPLIT → DONE_B.
  - otherwise (abort code, skip of ≥2 steps, accept in wrong range, unknown) → INVALID.
- Terminal states ignore Controle; left only by Limpar (→IDLE) or Reset.
- Timeout (TIMEOUT>0): counter clears on every strobe and on entering ACTIVE; increments each ACTIVE cycle without strobe; when it equals TIMEOUT → INVALID next edge. Inactive outside ACTIVE.
- Table writes accepted only in IDLE; silently dropped otherwise. Write and strobe in the same IDLE cycle: strobe compared against pre-write table.
- Limpar has priority over strobe, timeout and prog_we (write dropped that cycle).
- Duplicate table entries resolved solely by the priority order above.

## Timing
- All outputs registered; state/estado/Saida update on the edge that samples the strobe (visible 1 cycle after strobe presented).
- fim high exactly the cycle after a terminal transition edge; low otherwise, including while held in a terminal state.
- Reset (async, Reset=0): state IDLE, estado 0, Saida 00, fim 0, timer 0, table = DEFAULT_TABLE. Reset mid-sequence discards progress immediately without waiting for clk.
- Back-to-back strobes every cycle supported; no stall, no backpressure.
- Timeout: with last strobe at edge e, INVALID at edge e+TIMEOUT+1 if no strobe in between.

## Test plan
- Defaults, strobes C1,C2,C3,C4,C5 → estado 1..5, Saida 00; then C8 (1010011) → Saida 10, fim one pulse, estado 0.
- Correction walk: C1..C5 then C4,C3,C2,C1 → estado 5,4,3,2,1; then C6 (1001001) → Saida 01.
- Invalid: C1 then C3 → Saida 11; C4 then C6 (accept-A at depth 4) → 11; C2-depth then C7 → 11; further strobes leave 11, Limpar → IDLE.
- Program: in IDLE write addr 0 = 7'b0000001; strobe 1100000 → stays IDLE; strobe 0000001 → estado 1; prog_we while ACTIVE → table unchanged.
- TIMEOUT=4: C1 then no strobe → Saida 11 at 5th edge; strobe at 4th idle cycle prevents it.
- Async Reset asserted between clock edges at estado 3 → outputs 0 immediately; Limpar with simultaneous C1 strobe in IDLE → stays IDLE.

Source files
------------

// File: rtl/decodificador_seq_param.sv
// Parametrised sequence decoder.
// Consumes one CHAR_W-bit character per Controle strobe and tracks progress
// through a SEQ_LEN-character code. Single-step corrections are allowed. The
// decoder ends in accept-A, accept-B or invalid. The code table can be
// reprogrammed at runtime while the decoder is in IDLE.
//
// Ports:
//   clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   Limpar     synchronous clear to IDLE (priority over everything else)
//   Controle   character strobe; Entrada is consumed on each edge where high
//   Entrada    character
//   prog_we    table write enable (honoured only in IDLE)
//   prog_addr  table entry: 0..SEQ_LEN-1 = C1..Cn, SEQ_LEN = accept-A,
//              SEQ_LEN+1 = abort, SEQ_LEN+2 = accept-B
//   prog_data  table entry value
//   estado     current depth (0 outside ACTIVE)
//   Saida      00 idle/running, 01 DONE_A, 10 DONE_B, 11 INVALID
//   fim        one-cycle pulse after entering any terminal state
module decodificador_seq_param #(
    parameter int unsigned CHAR_W  = 7,
    parameter int unsigned SEQ_LEN = 5,
    parameter int unsigned SPLIT   = 3,
    parameter int unsigned TIMEOUT = 0,
    parameter logic [CHAR_W*(SEQ_LEN+3)-1:0] DEFAULT_TABLE = {
        7'b1010011, 7'b1110101, 7'b1001001, 7'b1101110,
        7'b1011010, 7'b1111100, 7'b1000100, 7'b1100000},
    localparam int unsigned DW = $clog2(SEQ_LEN+1),
    localparam int unsigned AW = $clog2(SEQ_LEN+3)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Limpar,
    input  logic              Controle,
    input  logic [CHAR_W-1:0] Entrada,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [CHAR_W-1:0] prog_data,
    output logic [DW-1:0]     estado,
    output logic [1:0]        Saida,
    output logic              fim
);

    localparam int unsigned NENT = SEQ_LEN + 3;
    localparam int unsigned TBLW = CHAR_W * NENT;
    localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

    localparam logic [AW-1:0] IDX_C1    = AW'(0);
    localparam logic [AW-1:0] IDX_ACC_A = AW'(SEQ_LEN);
    localparam logic [AW-1:0] IDX_ACC_B = AW'(SEQ_LEN + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE_A,
        ST_DONE_B,
        ST_INVALID
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        saida_q, saida_d;
    logic              fim_q, fim_d;
    logic [TBLW-1:0]   tbl_q, tbl_d;

    // Table index of the next, current and previous code characters
    // relative to depth k: T[k], T[k-1], T[k-2].
    logic [AW-1:0]     idx_next, idx_cur, idx_prev;
    logic              m_next, m_cur, m_prev, m_acc_a, m_acc_b, m_c1;
    logic              term_q, term_d;

    assign idx_next = AW'(depth_q);
    assign idx_cur  = AW'(depth_q) - AW'(1);
    assign idx_prev = AW'(depth_q) - AW'(2);

    // Match flags against the current (pre-write) table contents.
    assign m_c1    = (Entrada == tbl_q[32'(IDX_C1)*CHAR_W +: CHAR_W]);
    assign m_next  = (depth_q < DW'(SEQ_LEN)) &&
                     (Entrada == tbl_q[32'(idx_next)*CHAR_W +: CHAR_W]);
    assign m_cur   = (Entrada == tbl_q[32'(idx_cur)*CHAR_W +: CHAR_W]);
    assign m_prev  = (depth_q >= DW'(2)) &&
                     (Entrada == tbl_q[32'(idx_prev)*CHAR_W +: CHAR_W]);
    assign m_acc_a = (depth_q <= DW'(SPLIT)) &&
                     (Entrada == tbl_q[32'(IDX_ACC_A)*CHAR_W +: CHAR_W]);
    assign m_acc_b = (depth_q > DW'(SPLIT)) &&
                     (Entrada == tbl_q[32'(IDX_ACC_B)*CHAR_W +: CHAR_W]);

    // Next-state, depth, timer, table and output computation.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        timer_d = '0;
        tbl_d   = tbl_q;
        saida_d = 2'b00;
        fim_d   = 1'b0;
        term_q  = 1'b0;
        term_d  = 1'b0;

        if (Limpar) begin
            state_d = ST_IDLE;
            depth_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prog_we && (32'(prog_addr) < NENT)) begin
                        tbl_d[32'(prog_addr)*CHAR_W +: CHAR_W] = prog_data;
                    end
                    if (Controle && m_c1) begin
                        state_d = ST_ACTIVE;
                        depth_d = DW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (Controle) begin
                        // First match wins; timer restarts on any strobe.
                        if (m_next) begin
                            depth_d = depth_q + DW'(1);
                        end else if (m_cur) begin
                            depth_d = depth_q;
                        end else if (m_prev) begin
                            depth_d = depth_q - DW'(1);
                        end else if (m_acc_a) begin
                            state_d = ST_DONE_A;
                            depth_d = '0;
                        end else if (m_acc_b) begin
                            state_d = ST_DONE_B;
                            depth_d = '0;
                        end else begin
                            state_d = ST_INVALID;
                            depth_d = '0;
                        end
                    end else if ((TIMEOUT > 0) && (timer_q == TW'(TIMEOUT))) begin
                        state_d = ST_INVALID;
                        depth_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    // Terminal states hold until Limpar or Reset.
                end
            endcase
        end

        case (state_d)
            ST_DONE_A:  saida_d = 2'b01;
            ST_DONE_B:  saida_d = 2'b10;
            ST_INVALID: saida_d = 2'b11;
            default:    saida_d = 2'b00;
        endcase

        term_q = (state_q == ST_DONE_A) || (state_q == ST_DONE_B) ||
                 (state_q == ST_INVALID);
        term_d = (state_d == ST_DONE_A) || (state_d == ST_DONE_B) ||
                 (state_d == ST_INVALID);
        fim_d  = term_d && !term_q;
    end

    // State, table and output registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            timer_q <= '0;
            saida_q <= 2'b00;
            fim_q   <= 1'b0;
            tbl_q   <= DEFAULT_TABLE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            timer_q <= timer_d;
            saida_q <= saida_d;
            fim_q   <= fim_d;
            tbl_q   <= tbl_d;
        end
    end

    assign estado = depth_q;
    assign Saida  = saida_q;
    assign fim    = fim_q;

endmodule
